// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card/PIN session controller with retry lockout and balance/deposit/withdraw/transfer sequencing.
// Define ATM_DAILY_LIMIT_EN to cap the per-session withdraw total at WD_LIMIT.
module atm_session_ctrl #(
   parameter int NUM_ACCTS = 4,
   parameter int BAL_W = 16,
   parameter int MAX_TRIES = 3,
   parameter logic [NUM_ACCTS*12-1:0] CARD_LIST = {12'd2100, 12'd2000, 12'd1988, 12'd1873},
   parameter logic [NUM_ACCTS*8-1:0] PIN_LIST = {8'h11, 8'h22, 8'h24, 8'h4F},
   parameter logic [NUM_ACCTS*BAL_W-1:0] BAL_LIST = {16'd0, 16'd100, 16'd500, 16'd50000},
   parameter int WD_LIMIT = 600
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [11:0]      i_card_number,
   input  logic [7:0]       i_pin_number,
   input  logic             i_txn_valid,
   output logic             o_txn_ready,
   input  logic [1:0]       i_txn_option,
   input  logic [9:0]       i_dollars,
   input  logic [11:0]      i_wired_account,
   input  logic             i_end_session,
   output logic             o_session_active,
   output logic             o_done,
   output logic             o_error,
   output logic [2:0]       o_err_code,
   output logic [BAL_W-1:0] o_balance,
   output logic             o_locked
);
`ifdef ATM_DAILY_LIMIT_EN
   localparam bit LIM_EN = 1'b1;
`else
   localparam bit LIM_EN = 1'b0;
`endif
   localparam int IW = $clog2(NUM_ACCTS);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam int BW1 = BAL_W + 1;
   typedef enum logic [2:0] {IDLE, LOOKUP, AUTH, READY, EXEC, XLOOK, RESP} state_t;
   state_t r_state, w_next;
   logic [11:0] r_card, r_wired;
   logic [7:0] r_pin;
   logic [1:0] r_opt;
   logic [9:0] r_dol;
   logic [IW-1:0] r_src, w_hidx, w_didx;
   logic [BAL_W-1:0] r_bal [NUM_ACCTS];
   logic [TW-1:0] r_tries [NUM_ACCTS];
   logic [NUM_ACCTS-1:0] r_lock;
   logic [31:0] r_total;
   logic r_active, r_locked;
   logic [2:0] r_err, w_err;
   logic [BAL_W-1:0] r_balance, w_new_src;
   logic w_hit, w_dhit, w_wr_src, w_wr_dst, w_accept, w_insuf, w_lim, w_pin_ok;
   logic [BAL_W:0] w_src, w_dst, w_dep, w_sub, w_xdst;
   always_comb begin
      w_hit = 1'b0;
      w_hidx = '0;
      w_dhit = 1'b0;
      w_didx = '0;
      for (int k = 0; k < NUM_ACCTS; k++) begin
         if (CARD_LIST[k*12 +: 12] == r_card) begin
            w_hit = 1'b1;
            w_hidx = IW'(k);
         end
         if (CARD_LIST[k*12 +: 12] == r_wired) begin
            w_dhit = 1'b1;
            w_didx = IW'(k);
         end
      end
   end
   // one extra bit of headroom so overflow and underflow are detected, never wrapped
   assign w_src = {1'b0, r_bal[r_src]};
   assign w_dst = {1'b0, r_bal[w_didx]};
   assign w_dep = w_src + BW1'(r_dol);
   assign w_sub = w_src - BW1'(r_dol);
   assign w_xdst = w_dst + BW1'(r_dol);
   assign w_insuf = BW1'(r_dol) > w_src;
   assign w_lim = LIM_EN && (r_total + 32'(r_dol) > 32'(WD_LIMIT));
   assign w_pin_ok = r_pin == PIN_LIST[r_src*8 +: 8];
   assign w_accept = i_txn_valid && o_txn_ready;
   assign w_new_src = (r_opt == 2'b01) ? w_dep[BAL_W-1:0] : w_sub[BAL_W-1:0];
   always_comb begin
      w_next = r_state;
      w_err = 3'd0;
      w_wr_src = 1'b0;
      w_wr_dst = 1'b0;
      case (r_state)
         IDLE:   w_next = i_start ? LOOKUP : IDLE;
         LOOKUP: begin
            w_next = w_hit ? AUTH : RESP;
            w_err = w_hit ? 3'd0 : 3'd1;
         end
         AUTH:   begin
            w_next = RESP;
            w_err = r_lock[r_src] ? 3'd3 : (w_pin_ok ? 3'd0 : 3'd2);
         end
         READY:  w_next = i_end_session ? IDLE : (w_accept ? EXEC : READY);
         EXEC:   begin
            w_next = (r_opt == 2'b11) ? XLOOK : RESP;
            w_err = (r_opt == 2'b01) ? (w_dep[BAL_W] ? 3'd5 : 3'd0) :
                    (r_opt == 2'b10) ? (w_insuf ? 3'd4 : (w_lim ? 3'd7 : 3'd0)) : 3'd0;
            w_wr_src = (r_opt == 2'b01 || r_opt == 2'b10) && w_err == 3'd0;
         end
         XLOOK:  begin
            w_next = RESP;
            w_err = (!w_dhit || w_didx == r_src) ? 3'd6 : (w_insuf ? 3'd4 : (w_xdst[BAL_W] ? 3'd5 : 3'd0));
            w_wr_src = w_err == 3'd0;
            w_wr_dst = w_err == 3'd0;
         end
         RESP:   w_next = r_active ? READY : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
         r_card <= '0;
         r_pin <= '0;
         r_opt <= '0;
         r_dol <= '0;
         r_wired <= '0;
         r_src <= '0;
         r_lock <= '0;
         r_total <= '0;
         r_active <= 1'b0;
         r_locked <= 1'b0;
         r_err <= '0;
         r_balance <= '0;
         for (int k = 0; k < NUM_ACCTS; k++) begin
            r_bal[k] <= BAL_LIST[k*BAL_W +: BAL_W];
            r_tries[k] <= '0;
         end
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && i_start) begin
            r_card <= i_card_number;
            r_pin <= i_pin_number;
            r_locked <= 1'b0;
         end
         if (r_state == LOOKUP) r_src <= w_hidx;
         if (w_accept) begin
            r_opt <= i_txn_option;
            r_dol <= i_dollars;
            r_wired <= i_wired_account;
         end
         if (w_next == RESP) r_err <= w_err;
         if (r_state == AUTH) begin
            if (r_lock[r_src]) r_locked <= 1'b1;
            else if (!w_pin_ok) begin
               r_tries[r_src] <= r_tries[r_src] + TW'(1);
               if (r_tries[r_src] + TW'(1) == TW'(MAX_TRIES)) r_lock[r_src] <= 1'b1;
            end else begin
               r_tries[r_src] <= '0;
               r_active <= 1'b1;
               r_balance <= r_bal[r_src];
            end
         end
         // source and destination commit on the same edge, so a transfer is never half-done
         if (w_wr_src) begin
            r_bal[r_src] <= w_new_src;
            r_balance <= w_new_src;
         end
         if (w_wr_dst) r_bal[w_didx] <= w_xdst[BAL_W-1:0];
         if (w_wr_src && r_state == EXEC && r_opt == 2'b10) r_total <= r_total + 32'(r_dol);
         if (r_state == READY && i_end_session) begin
            r_active <= 1'b0;
            r_balance <= '0;
            r_total <= '0;
         end
      end
   end
   assign o_txn_ready = (r_state == READY) && !i_end_session;
   assign o_session_active = r_active;
   assign o_done = r_state == RESP;
   assign o_error = o_done && r_err != 3'd0;
   assign o_err_code = r_err;
   assign o_balance = r_balance;
   assign o_locked = r_locked;
endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Session and transaction controller for the ATM account datapath.
- Authenticates a card/PIN pair against a small internal account table and enforces PIN-retry lockout.
- Sequences balance, deposit, withdraw and transfer operations on the per-account balance registers.
- Reports result, error code and updated balance to the front-end/menu logic and the test bench.

Parameters:
- NUM_ACCTS, 4, number of accounts in the table (2..8).
- BAL_W, 16, balance register width in bits.
- MAX_TRIES, 3, consecutive bad PINs before an account locks.
- CARD_LIST, {12'd2100,12'd2000,12'd1988,12'd1873}, packed 12-bit card numbers; index 0 in the LSBs.
- PIN_LIST, {8'h11,8'h22,8'h24,8'h4F}, packed 8-bit PINs, same order as CARD_LIST.
- BAL_LIST, {16'd0,16'd100,16'd500,16'd50000}, packed initial balances, same order.
- WD_LIMIT, 600, per-session withdraw cap; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  card-insert pulse; sampled in IDLE only.
- card_number  in  12  card presented with start.
- pin_number  in  8  PIN presented with start.
- txn_valid  in  1  transaction request valid.
- txn_ready  out  1  controller can accept a transaction.
- txn_option  in  2  00 balance, 01 deposit, 10 withdraw, 11 transfer.
- dollars  in  10  amount, 0..1023.
- wired_account  in  12  destination card number for a transfer.
- end_session  in  1  card-eject request.
- session_active  out  1  high while authenticated.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse coincident with done on failure.
- err_code  out  3  valid with done; holds until the next done.
- balance  out  BAL_W  balance of the authenticated account.
- locked  out  1  last authentication hit a locked account.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - Balances reload from BAL_LIST.
  - Retry counters and lock bits clear.
  - Per-session withdraw total is 0.
- States: IDLE, LOOKUP, AUTH, READY, EXEC, XLOOK, RESP.
- IDLE:
  - On start, latch card_number and pin_number, then go to LOOKUP.
  - Other inputs are ignored.
- LOOKUP (1 cycle): parallel compare against CARD_LIST and register the hit index.
  - No match: err_code 1, go to RESP, then IDLE.
- AUTH (1 cycle):
  - Locked account: err_code 3, locked=1, session does not open.
  - PIN mismatch: increment the retry count; err_code 2; on reaching MAX_TRIES, set the lock bit.
  - PIN match: clear the retry count, session_active=1, balance shows the account balance, go to READY.
  - Every AUTH outcome passes through RESP, which pulses done. Failure returns to IDLE; success goes to READY.
- READY:
  - txn_ready = (state==READY) && !end_session.
  - A handshake (txn_valid && txn_ready) captures option, dollars and wired_account, then goes to EXEC.
  - end_session wins over txn_valid in the same cycle. It clears session_active and balance, zeroes the withdraw total, returns to IDLE, and pulses no done.
  - start while a session is active is ignored.
- EXEC (1 cycle):
  - 00 balance: no change.
  - 01 deposit: if balance+dollars > 2^BAL_W-1, err_code 5 and no change; otherwise add.
  - 10 withdraw: if dollars > balance, err_code 4 and no change; otherwise subtract.
  - 11 transfer: go to XLOOK.
  - Arithmetic is computed at BAL_W+1 bits. Nothing ever wraps.
- XLOOK (1 cycle):
  - Destination unknown, or equal to the source: err_code 6.
  - dollars > source balance: err_code 4.
  - Destination overflow: err_code 5.
  - Otherwise debit the source and credit the destination in the same edge.
- RESP:
  - done=1; error=1 iff err_code != 0.
  - balance updates on the same edge as the balance register write, so it is valid with done.
  - Returns to READY when a session is open, else IDLE.
- Latency from the accepting edge to done: balance/deposit/withdraw 2 cycles; transfer 3 cycles. From the start edge to done: 3 cycles.
- err_code values: 0 ok, 1 unknown card, 2 bad PIN, 3 locked, 4 insufficient funds, 5 overflow, 6 bad destination, 7 limit exceeded.
- locked clears on the next start.
- Reset asserted mid-transaction aborts immediately. No partial transfer is possible because the debit and credit commit on one edge.

Optional Feature:
- Macro: ATM_DAILY_LIMIT_EN.
- Defined:
  - A withdraw whose dollars plus the session withdraw total exceeds WD_LIMIT fails with err_code 7 and no balance change.
  - A successful withdraw adds to the total.
  - The total clears on session end and on reset.
- Undefined: no limit check; error code 7 is never produced. Behaviour is otherwise identical.

Test Plan:
- Bad PIN: start with card 2133 (not in the table) and PIN 8'h55 -> done with error=1, err_code=1, session_active=0. Then card 1988 with PIN 8'h25 three times -> err_code 2,2,2. The fourth attempt, with PIN 8'h24, gives err_code 3 and locked=1.
- Withdraw: card 1873 with PIN 8'h4F -> session_active=1, balance 50000. Withdraw 250 -> done 2 cycles after the handshake, balance 49750, error=0.
- Insufficient funds: after reset, card 1988 with PIN 8'h24, withdraw 1000 -> err_code 4, balance stays 500.
- Transfer: card 1873, transfer 1000 to 1988 -> done in 3 cycles, source balance 48750. End the session, log in as 1988 -> balance 1500. A transfer to 1873 from its own session gives err_code 6.
- Overflow, concurrency and reset:
  - Deposit 1023 to a balance of 65000 -> err_code 5, no change.
  - end_session and txn_valid asserted together -> no done, back in IDLE.
  - reset pulsed while in EXEC -> all outputs 0 and balances restored to BAL_LIST.
- Limit, with ATM_DAILY_LIMIT_EN defined: withdraw 400 then 300 -> the second fails with err_code 7. With the macro undefined, both succeed.
